// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA loader) arbiter in front of a single fixed-latency memory.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise the CPU has fixed priority.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        en_nxt, we_nxt, owner_nxt;
    logic        cpu_ack_nxt, dma_ack_nxt;
    logic [31:0] addr_nxt, wdata_nxt, cpu_rdata_nxt, dma_rdata_nxt;
    logic        grant_dma;

`ifdef MEM_ARB_RR_EN
    logic last_dma, last_dma_nxt;

    // On a tie the port that was not granted last wins; reset leaves last = DMA so the CPU goes first.
    assign grant_dma = dma_req && (!cpu_req || !last_dma);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_dma <= 1'b1;
        else     last_dma <= last_dma_nxt;
    end
`else
    assign grant_dma = dma_req && !cpu_req;
`endif

    assign busy = (state == ACCESS) || (state == DONE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt     = state;
        cnt_nxt       = cnt;
        en_nxt        = mem_en;
        we_nxt        = mem_we;
        addr_nxt      = mem_addr;
        wdata_nxt     = mem_wdata;
        owner_nxt     = owner;
        cpu_rdata_nxt = cpu_rdata;
        dma_rdata_nxt = dma_rdata;
        cpu_ack_nxt   = 1'b0;
        dma_ack_nxt   = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_dma_nxt  = last_dma;
`endif
        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_nxt = grant_dma;
                    addr_nxt  = grant_dma ? dma_addr  : cpu_addr;
                    wdata_nxt = grant_dma ? dma_wdata : cpu_wdata;
                    we_nxt    = grant_dma ? dma_we    : cpu_we;
                    en_nxt    = 1'b1;
                    cnt_nxt   = LAT_INIT;
                    state_nxt = ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_dma_nxt = grant_dma;
`endif
                end
            end
            ACCESS: begin
                cnt_nxt = cnt - 4'd1;
                // Final access cycle: memory data is valid now, so capture it for the owner.
                if (cnt == 4'd1) begin
                    if (!mem_we) begin
                        if (owner) dma_rdata_nxt = mem_rdata;
                        else       cpu_rdata_nxt = mem_rdata;
                    end
                    en_nxt      = 1'b0;
                    we_nxt      = 1'b0;
                    cpu_ack_nxt = !owner;
                    dma_ack_nxt = owner;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                en_nxt    = 1'b0;
                we_nxt    = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            owner     <= 1'b0;
            cpu_rdata <= 32'd0;
            dma_rdata <= 32'd0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_en    <= en_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            owner     <= owner_nxt;
            cpu_rdata <= cpu_rdata_nxt;
            dma_rdata <= dma_rdata_nxt;
            cpu_ack   <= cpu_ack_nxt;
            dma_ack   <= dma_ack_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random two-port traffic against a
// transaction-timeline reference model; a second MEM_LAT=1 instance covers back-to-back throughput.
module tb_mem_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, dma_ack, mem_en, mem_we, busy, owner;

    logic        c1_req;
    logic [31:0] c1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        c1_ack, d1_ack, m1_en, m1_we, busy1, owner1;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(L)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_arbiter #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(32'h0000_0020), .cpu_wdata(32'd0),
        .cpu_rdata(c1_rdata), .cpu_ack(c1_ack),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'd0), .dma_wdata(32'd0),
        .dma_rdata(d1_rdata), .dma_ack(d1_ack),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata), .busy(busy1), .owner(owner1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a transaction is a grant edge index g plus latched fields; everything
    // observable follows from the distance between the current edge and g.
    int          ecnt;
    bit          act;
    int          g;
    bit          m_own, m_we;
    logic [31:0] m_addr, m_wdata, m_rd;
    bit          last_dma;
    logic [31:0] x_crd, x_drd, x_maddr, x_mwdata;
    bit          x_owner;
    int          grants[$];

    bit          directed;
    logic [31:0] rd_fix;
    bit          p_req[2], p_we[2], keep[2];
    logic [31:0] p_addr[2], p_wdata[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic new_req(input int p, input bit r);
        p_req[p]   = r;
        p_we[p]    = 1'($urandom_range(1));
        p_addr[p]  = $urandom;
        p_wdata[p] = $urandom;
    endtask

    task automatic apply_inputs();
        bit junk_c, junk_d;
        int d;
        d = ecnt - g;
        junk_c = act && d >= 1 && d <= L && !m_own;
        junk_d = act && d >= 1 && d <= L && m_own;
        cpu_req   = p_req[0];
        dma_req   = p_req[1];
        cpu_we    = junk_c ? 1'($urandom_range(1)) : p_we[0];
        dma_we    = junk_d ? 1'($urandom_range(1)) : p_we[1];
        cpu_addr  = junk_c ? $urandom : p_addr[0];
        dma_addr  = junk_d ? $urandom : p_addr[1];
        cpu_wdata = junk_c ? $urandom : p_wdata[0];
        dma_wdata = junk_d ? $urandom : p_wdata[1];
        mem_rdata = (act && d == L && !m_we) ? m_rd : $urandom;
        m1_rdata  = $urandom;
    endtask

    task automatic model_edge();
        int d;
        bit w;
        if (act) begin
            d = ecnt - g;
            if (d == L && !m_we) begin
                if (m_own) x_drd = m_rd;
                else       x_crd = m_rd;
            end
            if (d == L + 1) act = 0;
        end else if (p_req[0] || p_req[1]) begin
            if (p_req[0] && p_req[1]) begin
`ifdef MEM_ARB_RR_EN
                w = !last_dma;
`else
                w = 0;
`endif
            end else begin
                w = p_req[1];
            end
            act      = 1;
            g        = ecnt;
            m_own    = w;
            m_we     = p_we[w];
            m_addr   = p_addr[w];
            m_wdata  = p_wdata[w];
            m_rd     = directed ? rd_fix : $urandom;
            last_dma = w;
            x_owner  = w;
            x_maddr  = m_addr;
            x_mwdata = m_wdata;
            grants.push_back(int'(w));
        end
    endtask

    task automatic check_outputs();
        int  dd;
        bit  en, ackp;
        dd   = (ecnt - 1) - g;
        en   = act && dd < L;
        ackp = act && dd == L;
        check("mem_en",    32'(mem_en),    32'(en));
        check("mem_we",    32'(mem_we),    32'(en && m_we));
        check("busy",      32'(busy),      32'(act));
        check("cpu_ack",   32'(cpu_ack),   32'(ackp && !m_own));
        check("dma_ack",   32'(dma_ack),   32'(ackp && m_own));
        check("owner",     32'(owner),     32'(x_owner));
        check("cpu_rdata", cpu_rdata,      x_crd);
        check("dma_rdata", dma_rdata,      x_drd);
        check("mem_addr",  mem_addr,       x_maddr);
        check("mem_wdata", mem_wdata,      x_mwdata);
    endtask

    task automatic update_requesters();
        int dd;
        bit acked;
        dd = (ecnt - 1) - g;
        for (int p = 0; p < 2; p++) begin
            acked = act && dd == L && (int'(m_own) == p);
            if (acked) begin
                if (directed) begin
                    if (!keep[p]) p_req[p] = 0;
                end else begin
                    new_req(p, $urandom_range(3) != 0);
                end
            end else if (!directed && !p_req[p] && $urandom_range(2) == 0) begin
                new_req(p, 1);
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model, check after the next rising edge.
    task automatic tick();
        apply_inputs();
        model_edge();
        @(posedge clk);
        ecnt++;
        @(negedge clk);
        check_outputs();
        update_requesters();
    endtask

    // Called at a falling edge; reset takes effect immediately and is held across one rising edge.
    task automatic do_reset(input string tag);
        rst      = 1'b1;
        p_req[0] = 0;
        p_req[1] = 0;
        act      = 0;
        apply_inputs();
        #1;
        check({tag, "_mem_en"},    32'(mem_en),  32'd0);
        check({tag, "_busy"},      32'(busy),    32'd0);
        check({tag, "_cpu_ack"},   32'(cpu_ack), 32'd0);
        check({tag, "_cpu_rdata"}, cpu_rdata,    32'd0);
        check({tag, "_dma_rdata"}, dma_rdata,    32'd0);
        check({tag, "_owner"},     32'(owner),   32'd0);
        check({tag, "_mem_addr"},  mem_addr,     32'd0);
        x_crd = 0; x_drd = 0; x_maddr = 0; x_mwdata = 0;
        x_owner = 0; last_dma = 1;
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        ecnt = 0;
        g    = -100;
    endtask

    initial begin
        int en_cnt;
        int exp_g[4];
        rst = 1'b1; c1_req = 1'b0;
        directed = 1; rd_fix = 32'd0; keep[0] = 0; keep[1] = 0;
        new_req(0, 0); new_req(1, 0);
        ecnt = 0; g = -100; act = 0;
        apply_inputs();
        @(negedge clk);
        do_reset("rst0");

        // CPU read of 0x10 returning 0xDEADBEEF.
        rd_fix = 32'hDEAD_BEEF;
        p_req[0] = 1; p_we[0] = 0; p_addr[0] = 32'h10; p_wdata[0] = 32'h0;
        en_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            en_cnt += int'(mem_en);
        end
        check("rd_en_cycles", 32'(en_cnt), 32'd2);
        check("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // DMA write of 0x12345678 to 0x40.
        p_req[1] = 1; p_we[1] = 1; p_addr[1] = 32'h40; p_wdata[1] = 32'h1234_5678;
        tick();
        check("wr_addr",  mem_addr,  32'h40);
        check("wr_wdata", mem_wdata, 32'h1234_5678);
        check("wr_we",    32'(mem_we), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("wr_dma_rdata", dma_rdata, 32'd0);
        check("wr_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // Both ports requesting continuously for four transactions.
        do_reset("rst1");
        keep[0] = 1; keep[1] = 1;
        p_req[0] = 1; p_we[0] = 0; p_addr[0] = 32'h100;
        p_req[1] = 1; p_we[1] = 0; p_addr[1] = 32'h200;
        grants.delete();
        for (int i = 0; i < 14; i++) tick();
        keep[0] = 0; keep[1] = 0;
        for (int i = 0; i < 2; i++) tick();
        p_req[0] = 0; p_req[1] = 0;
        for (int i = 0; i < 2; i++) tick();
`ifdef MEM_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        check("arb_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check($sformatf("arb_grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));

        // Reset during the second access cycle of a CPU read.
        do_reset("rst2");
        rd_fix = 32'hCAFE_F00D;
        p_req[0] = 1; p_we[0] = 0; p_addr[0] = 32'h10;
        tick();
        tick();
        check("abort_pre_en", 32'(mem_en), 32'd1);
        do_reset("abort");
        for (int i = 0; i < 3; i++) tick();
        check("abort_cpu_rdata", cpu_rdata, 32'd0);

        // Random two-port traffic.
        directed = 0;
        for (int i = 0; i < 600; i++) tick();
        directed = 1;
        do_reset("rst3");

        // MEM_LAT=1 instance with the CPU request held high.
        c1_req = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("lat1_ack_%0d", k),  32'(c1_ack), 32'(k % 3 == 1));
            check($sformatf("lat1_busy_%0d", k), 32'(busy1),  32'(k % 3 != 2));
            check($sformatf("lat1_dack_%0d", k), 32'(d1_ack), 32'd0);
        end
        c1_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
